// File: rtl/data_memory_arbiter.sv
// Shares the single byte-addressed data memory between the pipeline MEM stage (cpu) and a
// debug/loader port (dbg). It adds access latency and checks alignment, range and funct3.
module data_memory_arbiter #(
   parameter int unsigned LATENCY        = 2,
   parameter int unsigned MEM_BYTES      = 1024,
   parameter int unsigned MAX_CPU_STREAK = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [2:0]  cpu_funct3,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [2:0]  dbg_funct3,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   output logic        dbg_done,
   output logic        dbg_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned STK_W = $clog2(MAX_CPU_STREAK + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_CPU_STREAK);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STK_W-1:0]  streak_q, streak_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic              err_q, err_d;

   logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
   logic              cpu_done_q, cpu_done_d, cpu_err_q, cpu_err_d;
   logic              dbg_done_q, dbg_done_d, dbg_err_q, dbg_err_d;
   logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [2:0]        mem_funct3_q, mem_funct3_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

   // Error if funct3 is illegal, access is misaligned, or it runs past the memory end.
   function automatic logic check_err(input logic [2:0] f3, input logic [AW-1:0] addr);
      logic [AW:0] last;
      logic        bad;
      bad  = 1'b0;
      last = {1'b0, addr};
      case (f3)
         3'b000:  last = {1'b0, addr} + (AW+1)'(1);
         3'b001:  begin last = {1'b0, addr} + (AW+1)'(2); bad = addr[0]; end
         3'b010:  begin last = {1'b0, addr} + (AW+1)'(4); bad = (addr[1:0] != 2'b00); end
         default: bad = 1'b1;
      endcase
      return bad | (last > (AW+1)'(MEM_BYTES));
   endfunction

   logic              any_req, grant_dbg, sel_we, sel_err;
   logic [2:0]        sel_f3;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;

   assign any_req   = cpu_req | dbg_req;
   assign grant_dbg = dbg_req & (~cpu_req | (streak_q == STK_MAX));
   assign sel_we    = grant_dbg ? dbg_we     : cpu_we;
   assign sel_f3    = grant_dbg ? dbg_funct3 : cpu_funct3;
   assign sel_addr  = grant_dbg ? dbg_addr   : cpu_addr;
   assign sel_wdata = grant_dbg ? dbg_wdata  : cpu_wdata;
   assign sel_err   = check_err(sel_f3, sel_addr);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state, latched transaction fields, latency counter and cpu streak.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      we_d     = we_q;
      f3_d     = f3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      streak_d = streak_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               owner_d = grant_dbg;
               we_d    = sel_we;
               f3_d    = sel_f3;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               err_d   = sel_err;
               cnt_d   = sel_err ? '0 : CNT_LOAD;
               state_d = sel_err ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == '0) state_d = S_RESP;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (!dbg_req) begin
         streak_d = '0;
      end else if (state_q == S_IDLE && any_req) begin
         if (grant_dbg)             streak_d = '0;
         else if (streak_q < STK_MAX) streak_d = streak_q + STK_W'(1);
      end
   end

   // Registered outputs are computed from the next state so they line up with it.
   always_comb begin
      cpu_rdata_d  = '0;
      cpu_done_d   = 1'b0;
      cpu_err_d    = 1'b0;
      dbg_rdata_d  = '0;
      dbg_done_d   = 1'b0;
      dbg_err_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_funct3_d = '0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      if (state_d == S_ACCESS) begin
         mem_read_d   = ~we_d;
         mem_write_d  = we_d & (cnt_d == '0);
         mem_funct3_d = f3_d;
         mem_addr_d   = addr_d;
         mem_wdata_d  = wdata_d;
      end
      if (state_q == S_ACCESS && cnt_q == '0 && !we_q) begin
         if (owner_q) dbg_rdata_d = mem_rdata;
         else         cpu_rdata_d = mem_rdata;
      end
      if (state_d == S_RESP) begin
         if (owner_d) begin
            dbg_done_d = 1'b1;
            dbg_err_d  = err_d;
         end else begin
            cpu_done_d = 1'b1;
            cpu_err_d  = err_d;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         streak_q     <= '0;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         f3_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_done_q   <= 1'b0;
         cpu_err_q    <= 1'b0;
         dbg_rdata_q  <= '0;
         dbg_done_q   <= 1'b0;
         dbg_err_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_funct3_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         cnt_q        <= cnt_d;
         streak_q     <= streak_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_done_q   <= cpu_done_d;
         cpu_err_q    <= cpu_err_d;
         dbg_rdata_q  <= dbg_rdata_d;
         dbg_done_q   <= dbg_done_d;
         dbg_err_q    <= dbg_err_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_funct3_q <= mem_funct3_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_done   = cpu_done_q;
   assign cpu_err    = cpu_err_q;
   assign cpu_stall  = cpu_req & ~cpu_done_q;
   assign dbg_rdata  = dbg_rdata_q;
   assign dbg_done   = dbg_done_q;
   assign dbg_err    = dbg_err_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_funct3 = mem_funct3_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
